i2si_sample_fifo: RTL



---
 rtl/i2si_pkg.sv | 18 +
 rtl/i2si_fifo_ram.sv | 39 +++
 rtl/i2si_sample_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/i2si_pkg.sv
// Shared sizing constants for the I2S input path.
package i2si_pkg;

    localparam int I2SI_DW         = 16;          // bits per channel word
    localparam int I2SI_FRAME_W    = 2 * I2SI_DW; // one stereo frame {lft, rgt}
    localparam int I2SI_FIFO_DEPTH = 8;           // stereo frames held
    localparam int I2SI_FIFO_AW    = 3;           // log2(I2SI_FIFO_DEPTH)
    localparam int I2SI_AF_THRESH  = 6;           // almost-full level

    // Pack one stereo frame with the left word in the upper half.
    function automatic logic [I2SI_FRAME_W-1:0] pack_frame(
        input logic [I2SI_DW-1:0] lft,
        input logic [I2SI_DW-1:0] rgt
    );
        return {lft, rgt};
    endfunction

endpackage

// File: rtl/i2si_fifo_ram.sv
// Frame storage for the sample FIFO: one write port and one registered
// read port. The read register holds its value until the next read.
module i2si_fifo_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Write one frame into the array.
    // NOTE: the array has no reset; pointers and level gate every read, so
    // stale contents are never observed and the storage stays a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-address write in the same cycle returns
    // the old contents, which is the oldest frame when the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/i2si_sample_fifo.sv
// Stereo-frame FIFO behind the I2S deserializer: captures {lft, rgt} on each
// frame strobe, pops frames on request and reports level and sticky status.
module i2si_sample_fifo
    import i2si_pkg::*;
#(
    parameter int DW        = I2SI_DW,
    parameter int DEPTH     = I2SI_FIFO_DEPTH,
    parameter int AW        = I2SI_FIFO_AW,
    parameter int AF_THRESH = I2SI_AF_THRESH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rf_i2si_en,
    input  logic [DW-1:0]   in_lft,
    input  logic [DW-1:0]   in_rgt,
    input  logic            in_xfc,
    input  logic            rd_en,
    output logic [2*DW-1:0] rd_data,
    output logic            rd_valid,
    output logic            fifo_empty,
    output logic            fifo_full,
    output logic [AW:0]     fifo_level,
    output logic            af_irq,
    output logic            ovf_sticky,
    output logic            unf_sticky,
    input  logic            sticky_clr
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW + 1)'(AF_THRESH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic          rd_ok;
    logic          wr;
    logic          ovf_set;
    logic          unf_set;

    // A pop at full frees a slot in the same cycle, so a concurrent frame
    // is accepted rather than dropped.
    assign rd_ok   = rd_en & rf_i2si_en & ~fifo_empty;
    assign wr      = in_xfc & rf_i2si_en & (~fifo_full | rd_ok);
    assign ovf_set = in_xfc & rf_i2si_en & fifo_full & ~rd_ok;
    assign unf_set = rd_en & rf_i2si_en & fifo_empty;

    // Status flags come straight from the registered level.
    assign fifo_level = level;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LVL);
    assign af_irq     = (level >= AF_LVL);

    // Level moves by one on a lone write or a lone read.
    // NOTE: next-state value is assigned a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        level_next = level;
        if (!rf_i2si_en) begin
            level_next = '0;
        end else if (wr && !rd_ok) begin
            level_next = level + 1'b1;
        end else if (rd_ok && !wr) begin
            level_next = level - 1'b1;
        end
    end

    // Pointer, level and read-strobe registers; disable flushes to empty.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else begin
            level    <= level_next;
            rd_valid <= rd_ok;
            if (!rf_i2si_en) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Sticky error flags; a set event outranks a clear in the same cycle.
    // They survive a disable so software can still read what went wrong.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= ovf_set | (ovf_sticky & ~sticky_clr);
            unf_sticky <= unf_set | (unf_sticky & ~sticky_clr);
        end
    end

    i2si_fifo_ram #(
        .W     (2 * DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_addr (wr_ptr),
        .wr_data ({in_lft, in_rgt}),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule
